operand_skid_buffer: RTL
========================

// Module: operand_skid_buffer
// PURPOSE
//  2-entry valid/ready skid buffer directly downstream of the 4-way operand mux.
//  Registers the selected 16-bit operand and its 2-bit select tag.
//  Breaks the combinational path from the mux output into the ALU stage.
//  Absorbs one extra word when the consumer stalls, so in_ready never depends combinationally on out_ready.
// PARAMETERS
//  WIDTH      16  data width of operand path
//  TAG_WIDTH  2   width of select tag carried alongside data (mux op code)
// PORTS
//  clk        in   1          system clock; all state updates on rising edge
//  reset      in   1          asynchronous, active-low reset
//  in_data    in   WIDTH      operand from 4-way mux output
//  in_sel     in   TAG_WIDTH  mux select that produced in_data
//  in_valid   in   1          in_data/in_sel valid this cycle
//  in_ready   out  1          buffer can accept a word this cycle
//  out_data   out  WIDTH      operand to consumer stage
//  out_sel    out  TAG_WIDTH  tag paired with out_data
//  out_valid  out  1          out_data/out_sel valid
//  out_ready  in   1          consumer accepts this cycle
//  flush      in   1          synchronous discard of all buffered words
//  occupancy  out  2          number of buffered words: 0, 1 or 2
//  stall_cnt  out  16         present only with OPERAND_STALL_CNT_EN
// BEHAVIOUR
//  - Handshakes:
//    - push = in_valid & in_ready.
//    - pop = out_valid & out_ready.
//  - State machine (registered), with two word registers MAIN (drives outputs) and SKID:
//    - EMPTY:
//      - push -> ONE; word loads MAIN.
//    - ONE:
//      - push & pop -> ONE; new word loads MAIN.
//      - push only -> FULL; new word loads SKID.
//      - pop only -> EMPTY.
//      - neither -> hold.
//    - FULL:
//      - pop -> ONE; SKID moves to MAIN.
//      - no pop -> hold.
//      - Push is impossible (in_ready=0).
//  - Combinational decode of registered state only:
//    - out_valid = (state != EMPTY).
//    - in_ready = (state != FULL).
//    - occupancy = 0/1/2 for EMPTY/ONE/FULL.
//    - No combinational path from out_ready or in_valid to any output.
//  - Latency: a word pushed into EMPTY appears on out_* the next cycle.
//    - Throughput is 1 word/cycle while out_ready=1.
//  - Ordering: strict FIFO. A word in SKID is always older than any later push.
//  - out_data/out_sel hold their last value after MAIN drains.
//    - Consumers qualify with out_valid.
//  - in_valid with in_ready=0: no state change. Upstream holds the word.
//  - flush:
//    - Highest priority: next state EMPTY; a same-cycle push is dropped.
//    - A same-cycle pop still completes on the consumer side.
//    - MAIN/SKID data contents are not cleared.
//  - Reset (async assert, sync-safe deassert by system):
//    - State = EMPTY.
//    - MAIN = SKID = 0.
//    - out_data=0, out_sel=0, out_valid=0, in_ready=1, occupancy=0.
//  - Reset mid-transfer: all buffered words are lost, and no output glitches to valid.
//  - Data widths are unmodified pass-through. No arithmetic is performed on the data.
// CONFIGURATION
//  - OPERAND_STALL_CNT_EN defined:
//    - stall_cnt port exists.
//    - Increments each cycle with out_valid=1 & out_ready=0.
//    - Saturates at 16'hFFFF.
//    - Cleared by reset only; flush does not clear it.
//  - OPERAND_STALL_CNT_EN undefined:
//    - Port and counter are absent.
//    - All other behaviour is identical.
// TESTING
//  - Reset: hold reset=0 4 cycles -> out_valid=0, in_ready=1, occupancy=0, out_data=16'h0000.
//  - Stream: out_ready=1; push 16'h0001..16'h0004 (sel 0..3) on consecutive cycles
//    -> same words/tags emerge one cycle later, one per cycle.
//  - Skid: push 16'h00AA then 16'h00BB with out_ready=0 -> occupancy=2, in_ready=0;
//    raise out_ready -> 16'h00AA then 16'h00BB, occupancy 1 then 0.
//  - Flush: occupancy=2, assert flush with in_valid=1 (16'h00CC)
//    -> next cycle out_valid=0, occupancy=0; 16'h00CC never appears.
//  - Async reset mid-stream: drop reset between clock edges with occupancy=1
//    -> out_valid=0 immediately; after release, next push 16'h1234 appears after 1 cycle.
//  - OPERAND_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5;
//    flush -> still 5; reset -> 0.

Source files
------------

// File: rtl/operand_skid_buffer.sv
// ---------------------------------------------------------------------------
// operand_skid_buffer
//   Two-entry valid/ready skid buffer placed after the 4-way operand mux.
//   Registers the selected operand and its select tag, cutting the timing
//   path from the mux into the ALU stage. A second (skid) register absorbs
//   one extra word on a consumer stall, so in_ready is a pure decode of
//   registered state and never depends on out_ready.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_data    operand from the mux            (WIDTH)
//   in_sel     mux select tag for in_data      (TAG_WIDTH)
//   in_valid   in_data/in_sel valid
//   in_ready   buffer can accept a word
//   out_data   operand to consumer             (WIDTH)
//   out_sel    tag paired with out_data        (TAG_WIDTH)
//   out_valid  out_data/out_sel valid
//   out_ready  consumer accepts this cycle
//   flush      synchronous discard of all buffered words
//   occupancy  number of buffered words, 0..2
//   stall_cnt  saturating stall counter (only with OPERAND_STALL_CNT_EN)
//
// Build option
//   OPERAND_STALL_CNT_EN : adds stall_cnt, counting cycles with
//                          out_valid=1 and out_ready=0; cleared by reset only.
// ---------------------------------------------------------------------------
module operand_skid_buffer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TAG_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [TAG_WIDTH-1:0] in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [TAG_WIDTH-1:0] out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [1:0]           occupancy
`ifdef OPERAND_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int unsigned OCC_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     main_data_q, main_data_d;
  logic [TAG_WIDTH-1:0] main_sel_q,  main_sel_d;
  logic [WIDTH-1:0]     skid_data_q, skid_data_d;
  logic [TAG_WIDTH-1:0] skid_sel_q,  skid_sel_d;

  logic push;
  logic pop;

  // Status outputs decode registered state only.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != ST_FULL);
    case (state_q)
      ST_ONE:  occupancy = OCC_WIDTH'(1);
      ST_FULL: occupancy = OCC_WIDTH'(2);
      default: occupancy = OCC_WIDTH'(0);
    endcase
  end

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_data_q;
  assign out_sel  = main_sel_q;

  // Next-state and word-register steering.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;

    if (flush) begin
      // Drop everything, including a same-cycle push; registers keep contents.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_sel_d  = in_sel;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_data_d = in_data;
            main_sel_d  = in_sel;
          end else if (push) begin
            // MAIN is stalled; the new (younger) word parks in SKID.
            state_d     = ST_FULL;
            skid_data_d = in_data;
            skid_sel_d  = in_sel;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and word registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
    end
  end

`ifdef OPERAND_STALL_CNT_EN
  localparam int unsigned CNT_WIDTH = 16;

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a valid word waits on the consumer.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // The unused fourth encoding must never be reached.
  a_legal_state: assert property (@(posedge clk) disable iff (!reset)
    state_q inside {ST_EMPTY, ST_ONE, ST_FULL});
`endif

endmodule
